// File: rtl/datapath_pkg.sv
// Shared constants for the accumulator executor: default widths, control-word
// bit positions and the executor FSM state encoding.
package datapath_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 12;

  localparam int unsigned CW_W    = 21;
  localparam int unsigned CW_USED = 13;

  localparam int unsigned CW_AR_PC  = 0;
  localparam int unsigned CW_IR_LD  = 1;
  localparam int unsigned CW_PC_INC = 2;
  localparam int unsigned CW_AR_IR  = 3;
  localparam int unsigned CW_MEM_RD = 4;
  localparam int unsigned CW_E_CLR  = 5;
  localparam int unsigned CW_E_CMA  = 6;
  localparam int unsigned CW_AC_CLR = 7;
  localparam int unsigned CW_AC_CMA = 8;
  localparam int unsigned CW_CIR    = 9;
  localparam int unsigned CW_CIL    = 10;
  localparam int unsigned CW_AC_INC = 11;
  localparam int unsigned CW_HALT   = 12;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    HALTED
  } state_t;

endpackage

// File: rtl/datapath_exec_ac_alu.sv
// Combinational AC/E operation unit: one prioritised AC operation per word,
// with rotates through E taking precedence over explicit E updates.
module ac_alu #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] ac,
  input  logic              e,
  input  logic              op_clr,
  input  logic              op_cma,
  input  logic              op_cir,
  input  logic              op_cil,
  input  logic              op_inc,
  input  logic              e_clr,
  input  logic              e_cma,
  output logic [DATA_W-1:0] ac_next,
  output logic              e_next
);

  always_comb begin
    ac_next = ac;
    e_next  = e;
    if (e_clr) begin
      e_next = 1'b0;
    end else if (e_cma) begin
      e_next = ~e;
    end

    // Rotates assign E after the explicit E ops so they win.
    if (op_clr) begin
      ac_next = '0;
    end else if (op_cma) begin
      ac_next = ~ac;
    end else if (op_cir) begin
      ac_next = {e, ac[DATA_W-1:1]};
      e_next  = ac[0];
    end else if (op_cil) begin
      ac_next = {ac[DATA_W-2:0], e};
      e_next  = ac[DATA_W-1];
    end else if (op_inc) begin
      ac_next = ac + 1'b1;
    end
  end

endmodule

// File: rtl/datapath_exec.sv
// Control-word executor: applies register transfers in one cycle, or defers
// them behind a memory read handshake when the word requests a read.
module datapath_exec
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cw_valid,
  output logic              cw_ready,
  input  logic [CW_W-1:0]   control_word,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ac_out,
  output logic              e_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] ar_out,
  output logic [DATA_W-1:0] ir_out,
  output logic              halted
);

  state_t               state;
  logic [DATA_W-1:0]    ac;
  logic                 e;
  logic [ADDR_W-1:0]    pc;
  logic [ADDR_W-1:0]    ar;
  logic [DATA_W-1:0]    ir;
  logic [CW_USED-1:0]   cw_q;
  logic [CW_USED-1:0]   exec_cw;
  logic                 accept;
  logic                 fire;
  logic [DATA_W-1:0]    ac_next;
  logic                 e_next;
  logic                 unused_rsvd;

  assign unused_rsvd = ^control_word[CW_W-1:CW_USED];

  assign cw_ready = (state == IDLE);
  assign accept   = cw_valid && cw_ready;

  // During a read the latched word drives the transfers applied at mem_ack.
  always_comb begin
    exec_cw = control_word[CW_USED-1:0];
    fire    = accept && !control_word[CW_MEM_RD];
    if (state == MEM_WAIT) begin
      exec_cw = cw_q;
      fire    = mem_ack;
    end
  end

  ac_alu #(
    .DATA_W(DATA_W)
  ) u_ac_alu (
    .ac      (ac),
    .e       (e),
    .op_clr  (exec_cw[CW_AC_CLR]),
    .op_cma  (exec_cw[CW_AC_CMA]),
    .op_cir  (exec_cw[CW_CIR]),
    .op_cil  (exec_cw[CW_CIL]),
    .op_inc  (exec_cw[CW_AC_INC]),
    .e_clr   (exec_cw[CW_E_CLR]),
    .e_cma   (exec_cw[CW_E_CMA]),
    .ac_next (ac_next),
    .e_next  (e_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cw_q     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (control_word[CW_MEM_RD]) begin
              cw_q     <= control_word[CW_USED-1:0];
              mem_req  <= 1'b1;
              mem_addr <= ar;
              state    <= MEM_WAIT;
            end else if (control_word[CW_HALT]) begin
              halted <= 1'b1;
              state  <= HALTED;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (cw_q[CW_HALT]) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ac <= '0;
      e  <= 1'b0;
      pc <= '0;
      ar <= '0;
      ir <= '0;
    end else if (fire) begin
      ac <= ac_next;
      e  <= e_next;
      if (exec_cw[CW_AR_IR]) begin
        ar <= ir[ADDR_W-1:0];
      end else if (exec_cw[CW_AR_PC]) begin
        ar <= pc;
      end
      if (exec_cw[CW_PC_INC]) begin
        pc <= pc + 1'b1;
      end
      if (exec_cw[CW_IR_LD] && exec_cw[CW_MEM_RD]) begin
        ir <= mem_rdata;
      end
    end
  end

  assign ac_out = ac;
  assign e_out  = e;
  assign pc_out = pc;
  assign ar_out = ar;
  assign ir_out = ir;

endmodule

// File: tb/tb_datapath_exec.sv
// Directed bench for datapath_exec: a transaction-level model checked every
// cycle, plus hand-computed literal checkpoints.
module tb_datapath_exec;

  localparam int DW = 16;
  localparam int AW = 12;

  localparam logic [20:0] W_AR_PC = 21'h1 << 0;
  localparam logic [20:0] W_IR    = 21'h1 << 1;
  localparam logic [20:0] W_PCI   = 21'h1 << 2;
  localparam logic [20:0] W_AR_IR = 21'h1 << 3;
  localparam logic [20:0] W_RD    = 21'h1 << 4;
  localparam logic [20:0] W_ECLR  = 21'h1 << 5;
  localparam logic [20:0] W_ECMA  = 21'h1 << 6;
  localparam logic [20:0] W_CLR   = 21'h1 << 7;
  localparam logic [20:0] W_CMA   = 21'h1 << 8;
  localparam logic [20:0] W_CIR   = 21'h1 << 9;
  localparam logic [20:0] W_CIL   = 21'h1 << 10;
  localparam logic [20:0] W_INC   = 21'h1 << 11;
  localparam logic [20:0] W_HLT   = 21'h1 << 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          cw_valid;
  logic          cw_ready;
  logic [20:0]   control_word;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ac_out;
  logic          e_out;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] ar_out;
  logic [DW-1:0] ir_out;
  logic          halted;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  datapath_exec #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cw_valid     (cw_valid),
    .cw_ready     (cw_ready),
    .control_word (control_word),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ac_out       (ac_out),
    .e_out        (e_out),
    .pc_out       (pc_out),
    .ar_out       (ar_out),
    .ir_out       (ir_out),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: architectural registers plus one outstanding read.
  logic [15:0] m_ac, m_ir;
  logic        m_e;
  logic [11:0] m_pc, m_ar, m_paddr;
  bit          m_halt, m_pend;
  logic [20:0] m_pcw;

  task automatic m_apply(input logic [20:0] w, input logic [15:0] rd);
    logic [16:0] x;
    logic [15:0] nac;
    logic        ne;
    logic [11:0] nar, npc;
    nac = m_ac;
    ne  = m_e;
    if (w[5]) ne = 1'b0;
    else if (w[6]) ne = !m_e;
    x = {m_e, m_ac};
    if (w[7]) nac = 16'h0;
    else if (w[8]) nac = ~m_ac;
    else if (w[9]) begin
      x = (x >> 1) | ((x & 17'd1) << 16);
      {ne, nac} = x;
    end else if (w[10]) begin
      x = (x << 1) | (x >> 16);
      {ne, nac} = x;
    end else if (w[11]) nac = 16'((int'(m_ac) + 1) % 65536);
    if (w[3]) nar = 12'(int'(m_ir) % 4096);
    else if (w[0]) nar = m_pc;
    else nar = m_ar;
    npc = w[2] ? 12'((int'(m_pc) + 1) % 4096) : m_pc;
    if (w[4] && w[1]) m_ir = rd;
    m_ac = nac;
    m_e  = ne;
    m_ar = nar;
    m_pc = npc;
    if (w[12]) m_halt = 1'b1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_ac = 0; m_e = 0; m_pc = 0; m_ar = 0; m_ir = 0;
      m_halt = 0; m_pend = 0; m_pcw = 0; m_paddr = 0;
    end else if (!m_halt) begin
      if (m_pend) begin
        if (mem_ack) begin
          m_apply(m_pcw, mem_rdata);
          m_pend = 0;
        end
      end else if (cw_valid) begin
        if (control_word[4]) begin
          m_pend  = 1;
          m_pcw   = control_word;
          m_paddr = m_ar;
        end else begin
          m_apply(control_word, 16'h0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("ac", 32'(ac_out), 32'(m_ac));
      chk("e", 32'(e_out), 32'(m_e));
      chk("pc", 32'(pc_out), 32'(m_pc));
      chk("ar", 32'(ar_out), 32'(m_ar));
      chk("ir", 32'(ir_out), 32'(m_ir));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("cw_ready", 32'(cw_ready), 32'(!m_pend && !m_halt));
      chk("mem_req", 32'(mem_req), 32'(m_pend));
      if (m_pend) chk("mem_addr", 32'(mem_addr), 32'(m_paddr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [20:0] w);
    cw_valid = 1'b1;
    control_word = w;
    step();
    cw_valid = 1'b0;
    control_word = '0;
  endtask

  task automatic ack(input logic [15:0] rd);
    mem_rdata = rd;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cw_valid = 1'b0; control_word = '0; mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    check_en = 1'b1;
    chk("rst_ac", 32'(ac_out), 32'h0);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    reset = 1'b0;
    step();
    chk("rst_ready", 32'(cw_ready), 32'h1);

    repeat (5) send(W_PCI);
    send(W_AR_PC | W_PCI);
    chk("arpc_ar", 32'(ar_out), 32'h005);
    chk("arpc_pc", 32'(pc_out), 32'h006);

    send(W_RD | W_IR);
    ack(16'h0010);
    send(W_AR_IR | W_AR_PC);
    chk("arir_prio", 32'(ar_out), 32'h010);

    send(W_RD | W_IR);
    mem_rdata = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("rd_addr", 32'(mem_addr), 32'h010);
      chk("rd_ready", 32'(cw_ready), 32'h0);
    end
    ack(16'h7801);
    chk("rd_ir", 32'(ir_out), 32'h7801);
    chk("rd_req_drop", 32'(mem_req), 32'h0);

    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    control_word = '1;
    step();
    control_word = '0;

    send(W_CLR); send(W_ECLR); send(W_ECMA); send(W_INC);
    send(W_CIR); send(W_INC); send(W_ECLR);
    chk("pre_cir_ac", 32'(ac_out), 32'h8001);
    send(W_CIR);
    chk("cir_ac", 32'(ac_out), 32'h4000);
    chk("cir_e", 32'(e_out), 32'h1);
    send(W_CIL);
    chk("cil_ac", 32'(ac_out), 32'h8001);
    chk("cil_e", 32'(e_out), 32'h0);

    send(W_CLR); send(W_CMA);
    send(W_CLR | W_INC);
    chk("clr_prio", 32'(ac_out), 32'h0000);
    send(W_CMA | W_ECMA);
    send(W_INC);
    chk("inc_wrap_ac", 32'(ac_out), 32'h0000);
    chk("inc_wrap_e", 32'(e_out), 32'h1);

    send(21'h1FE000 | W_INC);
    send(W_CIR | W_CIL | W_INC | W_ECLR);
    send(W_CIL | W_ECMA | W_CMA);
    send(W_CIL | W_ECMA);

    repeat (4089) send(W_PCI);
    chk("pc_max", 32'(pc_out), 32'hFFF);
    send(W_PCI);
    chk("pc_wrap", 32'(pc_out), 32'h000);

    send(W_CLR);
    repeat (255) send(W_INC);
    send(W_HLT | W_CMA);
    chk("hlt_ac", 32'(ac_out), 32'hFF00);
    chk("hlt_flag", 32'(halted), 32'h1);
    chk("hlt_ready", 32'(cw_ready), 32'h0);
    send(W_CLR); send(W_PCI | W_RD);
    ack(16'h1111);
    chk("hlt_ignore", 32'(ac_out), 32'hFF00);

    reset = 1'b1;
    step();
    reset = 1'b0;
    send(W_RD | W_IR);
    step(); step();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    reset = 1'b0; mem_ack = 1'b0;
    chk("abort_req", 32'(mem_req), 32'h0);
    chk("abort_ir", 32'(ir_out), 32'h0);

    send(W_RD | W_IR | W_HLT | W_PCI);
    step();
    chk("rdhlt_wait", 32'(halted), 32'h0);
    ack(16'h1234);
    chk("rdhlt_ir", 32'(ir_out), 32'h1234);
    chk("rdhlt_pc", 32'(pc_out), 32'h001);
    chk("rdhlt_flag", 32'(halted), 32'h1);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_exec.md
DATAPATH_EXEC -- requirements
Module: datapath_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the AC/IR/memory data width.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the AR/PC/memory address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cw_valid  input  1  control word present.
REQ-006 SHALL have port cw_ready  output  1  the executor accepts the control word this cycle.
REQ-007 SHALL have port control_word  input  21  the control word, bit map per REQ-012.
REQ-008 SHALL have ports mem_req (output, 1), mem_addr (output, ADDR_W), mem_ack (input, 1) and mem_rdata (input, DATA_W), forming the memory read handshake.
REQ-009 SHALL have outputs ac_out (DATA_W), e_out (1), pc_out (ADDR_W), ar_out (ADDR_W) and ir_out (DATA_W), each a direct register view.
REQ-010 SHALL have output halted (1), the halt latch.

Function
REQ-011 SHALL accept a control word only on a cycle with cw_valid=1 and cw_ready=1; with cw_valid=0, no register changes.
REQ-012 SHALL decode the control word bits as follows; bits [20:12] are reserved and ignored.
- [0] AR<-PC
- [1] IR<-mem_rdata (valid only with [4])
- [2] PC<-PC+1
- [3] AR<-IR[ADDR_W-1:0]
- [4] memory read
- [5] E<-0
- [6] E<-~E
- [7] AC<-0
- [8] AC<-~AC
- [9] CIR
- [10] CIL
- [11] AC<-AC+1
- [12] halt
REQ-013 SHALL run the FSM states IDLE, MEM_WAIT and HALTED; cw_ready=1 only in IDLE.
REQ-014 SHALL, on IDLE acceptance of a word without [4], apply all its register transfers at the same edge, giving one-cycle latency.
REQ-015 SHALL, on IDLE acceptance of a word with [4]:
- go to MEM_WAIT;
- latch the remaining word bits;
- drive mem_req=1 and mem_addr equal to the AR value at acceptance, holding both stable until mem_ack;
- at the mem_ack edge, apply all latched transfers (IR from mem_rdata if [1] is set), deassert mem_req next cycle and return to IDLE.
REQ-016 SHALL treat mem_ack as ignored while mem_req=0.
REQ-017 SHALL apply AC operations with priority CLR > CMA > CIR > CIL > INC, executing only the highest set.
REQ-018 SHALL perform CIR as AC<={E,AC[DATA_W-1:1]}, E<=AC[0].
REQ-019 SHALL perform CIL as AC<={AC[DATA_W-2:0],E}, E<=AC[DATA_W-1].
REQ-020 SHALL perform INC modulo 2^DATA_W with E unchanged, so 0xFFFF->0x0000.
REQ-021 SHALL let a rotate's E update override [5]/[6]; otherwise [5] takes priority over [6].
REQ-022 SHALL wrap PC increment modulo 2^ADDR_W, so 0xFFF->0x000.
REQ-023 SHALL give AR the pre-increment PC when [0] and [2] are set together.
REQ-024 SHALL give [3] priority over [0] when both are set.
REQ-025 SHALL, for [12], apply the word's other transfers, then enter HALTED with halted=1 and cw_ready=0.
REQ-026 SHALL leave HALTED only through reset.
REQ-027 SHALL, when [12] and [4] are both set, complete the read first and then enter HALTED.

Reset
REQ-028 SHALL, on reset=1 at a rising edge:
- set AC, E, PC, AR and IR to 0;
- set halted=0 and mem_req=0;
- set the state to IDLE;
- leave cw_ready=1 from the following cycle.
REQ-029 SHALL, on reset during MEM_WAIT, abort the read, discard any mem_ack in that cycle and leave IR unchanged from its reset value.
REQ-030 SHALL give reset priority over every simultaneous event.

Structure
REQ-031 SHALL take control-word bit index constants, the FSM state enumeration and the DATA_W/ADDR_W defaults from the shared package datapath_pkg.
REQ-032 SHALL place the combinational AC/E operation unit (REQ-017 to REQ-021) in sub-module ac_alu; all registers stay in datapath_exec.

Verification
REQ-033 SHALL cover: reset, then word [0]|[2] with PC=0x005 -> AR=0x005 and PC=0x006 one cycle later.
REQ-034 SHALL cover: word [4]|[1] with AR=0x010, mem_ack delayed 3 cycles, rdata=0x7801 -> mem_addr=0x010 held, cw_ready=0 for 4 cycles, then IR=0x7801.
REQ-035 SHALL cover: AC=0x8001 and E=0, word [9] -> AC=0x4000, E=1; then word [10] -> AC=0x8001, E=0.
REQ-036 SHALL cover: AC=0xFFFF, word [7]|[11] -> AC=0x0000; then word [11] with AC=0xFFFF and E=1 -> AC=0x0000, E=1.
REQ-037 SHALL cover: word [12]|[8] with AC=0x00FF -> AC=0xFF00, halted=1; later words ignored until reset.
REQ-038 SHALL cover: reset asserted mid-MEM_WAIT together with mem_ack -> mem_req=0 and IR=0 next cycle.
